// File: rtl/juke_pkg.sv
// Shared definitions for the jukebox playback controller.
// Contents: FSM state enum, rest-note period threshold, default bus widths,
// and the helper that converts a duration code into a timer load value.
package juke_pkg;

  localparam int DEF_IDX_W   = 10;  // note index width
  localparam int DEF_PER_W   = 20;  // note period width (clock cycles per half-wave)
  localparam int DEF_DUR_W   = 5;   // duration code width (units)
  localparam int REST_PERIOD = 1;   // a period at or below this value is a rest
  localparam int TIMER_W     = 32;  // duration timer width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_PAUSED = 2'd3
  } juke_state_e;

  // A duration code of 0 plays as one unit. The product is formed at the full
  // timer width so long notes at the real clock rate are not truncated.
  function automatic logic [TIMER_W-1:0] note_ticks(input logic [TIMER_W-1:0] dur,
                                                    input logic [TIMER_W-1:0] ticks_per_unit);
    logic [TIMER_W-1:0] units_s;
    if (dur == {TIMER_W{1'b0}}) begin
      units_s = {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      units_s = dur;
    end
    return (units_s * ticks_per_unit) - {{(TIMER_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/juke_sequencer_if.sv
// Song ROM fetch bus used between the playback controller and the song ROM.
//   rom_req    : fetch request, held until rom_ack
//   rom_song   : song number presented to the ROM
//   rom_addr   : note index presented to the ROM
//   rom_ack    : ROM data valid, completes the fetch
//   rom_period : note period (<= REST_PERIOD means rest)
//   rom_dur    : note duration in units
// Modports: master = sequencer side, slave = ROM side.
interface juke_sequencer_if
  import juke_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int PER_W = DEF_PER_W,
  parameter int DUR_W = DEF_DUR_W
);

  logic             rom_req;
  logic [1:0]       rom_song;
  logic [IDX_W-1:0] rom_addr;
  logic             rom_ack;
  logic [PER_W-1:0] rom_period;
  logic [DUR_W-1:0] rom_dur;

  modport master (
    output rom_req, rom_song, rom_addr,
    input  rom_ack, rom_period, rom_dur
  );

  modport slave (
    input  rom_req, rom_song, rom_addr,
    output rom_ack, rom_period, rom_dur
  );

endinterface

// File: rtl/juke_dur_timer.sv
// Note duration down-counter.
//   clock, resetn : clock and asynchronous active-low reset
//   load          : load load_val (takes priority over en)
//   load_val      : ticks remaining minus one for the new note
//   en            : decrement by one, saturating at zero
//   zero          : count has reached zero
module juke_dur_timer
  import juke_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count_r;

  // Count register: load a fresh note, or step down while playing.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_r <= {TIMER_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {TIMER_W{1'b0}})) begin
      count_r <= count_r - {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {TIMER_W{1'b0}});

endmodule

// File: rtl/juke_sequencer.sv
// Jukebox playback controller. Latches a song selection, fetches notes from
// the song ROM one at a time over a req/ack bus, times each note and drives
// the tone generator. Supports play, pause, stop and end-of-song.
// Ports:
//   clock, resetn  : clock and asynchronous active-low reset
//   song_sel       : requested song, 0 = none
//   play_req       : 1-cycle pulse, start song_sel (ignored while busy)
//   stop_req       : 1-cycle pulse, abort playback (wins over play_req)
//   pause          : level, freeze playback while high
//   rom            : song ROM fetch bus (master side)
//   tone_period    : period to the tone generator
//   tone_en        : tone generator enable
//   busy           : high in every state except IDLE
//   done           : 1-cycle pulse when the last note finishes
// Build option: JUKE_AUTOLOOP_EN restarts the song from note 0 after the
// last note instead of returning to IDLE.
module juke_sequencer
  import juke_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 12_500_000,
  parameter int SONG_LEN       = 59,
  parameter int IDX_W          = DEF_IDX_W,
  parameter int PER_W          = DEF_PER_W,
  parameter int DUR_W          = DEF_DUR_W
)(
  input  logic              clock,
  input  logic              resetn,
  input  logic [1:0]        song_sel,
  input  logic              play_req,
  input  logic              stop_req,
  input  logic              pause,
  juke_sequencer_if.master  rom,
  output logic [PER_W-1:0]  tone_period,
  output logic              tone_en,
  output logic              busy,
  output logic              done
);

  localparam logic [TIMER_W-1:0] TPU_C   = TIMER_W'(TICKS_PER_UNIT);
  localparam logic [IDX_W-1:0]   LAST_C  = IDX_W'(SONG_LEN - 1);
  localparam logic [PER_W-1:0]   REST_C  = PER_W'(REST_PERIOD);

  juke_state_e        state_r, state_s;
  logic               rom_req_r, rom_req_s;
  logic [1:0]         rom_song_r, rom_song_s;
  logic [IDX_W-1:0]   rom_addr_r, rom_addr_s;
  logic [PER_W-1:0]   tone_period_r, tone_period_s;
  logic               tone_en_r, tone_en_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               timer_load_s, timer_en_s, timer_zero_s;
  logic [TIMER_W-1:0] timer_val_s;

  assign timer_val_s = note_ticks(TIMER_W'(rom.rom_dur), TPU_C);

  juke_dur_timer u_timer (
    .clock    (clock),
    .resetn   (resetn),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .en       (timer_en_s),
    .zero     (timer_zero_s)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_s       = state_r;
    rom_req_s     = rom_req_r;
    rom_song_s    = rom_song_r;
    rom_addr_s    = rom_addr_r;
    tone_period_s = tone_period_r;
    tone_en_s     = tone_en_r;
    done_s        = 1'b0;
    timer_load_s  = 1'b0;
    timer_en_s    = 1'b0;

    if (stop_req) begin
      // Abort from anywhere; a later ack is ignored because IDLE never looks at it.
      state_s    = ST_IDLE;
      rom_req_s  = 1'b0;
      rom_addr_s = {IDX_W{1'b0}};
      tone_en_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (play_req && (song_sel != 2'd0)) begin
            rom_song_s = song_sel;
            rom_addr_s = {IDX_W{1'b0}};
            rom_req_s  = 1'b1;
            state_s    = ST_FETCH;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (rom.rom_ack) begin
            tone_period_s = rom.rom_period;
            timer_load_s  = 1'b1;
            rom_req_s     = 1'b0;
            // A pause raised during the fetch takes effect as soon as the note is loaded.
            if (pause) begin
              tone_en_s = 1'b0;
              state_s   = ST_PAUSED;
            end else begin
              tone_en_s = (rom.rom_period > REST_C);
              state_s   = ST_PLAY;
            end
          end else begin
            tone_en_s = 1'b0;
          end
        end
        ST_PLAY: begin
          // Every PLAY cycle consumes one tick, including the one that raises pause,
          // so sounding time always equals the note length.
          timer_en_s = 1'b1;
          if (timer_zero_s) begin
            tone_en_s = 1'b0;
            if (rom_addr_r == LAST_C) begin
              done_s = 1'b1;
`ifdef JUKE_AUTOLOOP_EN
              rom_addr_s = {IDX_W{1'b0}};
              rom_req_s  = 1'b1;
              state_s    = ST_FETCH;
`else
              rom_addr_s = {IDX_W{1'b0}};
              state_s    = ST_IDLE;
`endif
            end else begin
              rom_addr_s = rom_addr_r + IDX_W'(1);
              rom_req_s  = 1'b1;
              state_s    = ST_FETCH;
            end
          end else if (pause) begin
            tone_en_s = 1'b0;
            state_s   = ST_PAUSED;
          end else begin
            state_s = ST_PLAY;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            tone_en_s = (tone_period_r > REST_C);
            state_s   = ST_PLAY;
          end else begin
            tone_en_s = 1'b0;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          rom_req_s = 1'b0;
          tone_en_s = 1'b0;
        end
      endcase
    end

    busy_s = (state_s != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rom_req_r     <= 1'b0;
      rom_song_r    <= 2'd0;
      rom_addr_r    <= {IDX_W{1'b0}};
      tone_period_r <= {PER_W{1'b0}};
      tone_en_r     <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      rom_req_r     <= rom_req_s;
      rom_song_r    <= rom_song_s;
      rom_addr_r    <= rom_addr_s;
      tone_period_r <= tone_period_s;
      tone_en_r     <= tone_en_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
    end
  end

  assign rom.rom_req  = rom_req_r;
  assign rom.rom_song = rom_song_r;
  assign rom.rom_addr = rom_addr_r;
  assign tone_period  = tone_period_r;
  assign tone_en      = tone_en_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_juke_sequencer.sv
// Self-checking bench for juke_sequencer with TICKS_PER_UNIT=4, SONG_LEN=3 and
// a ROM model that answers each request with a one-cycle ack. Expected note
// timings are computed from the note table: each note occupies
// max(dur,1)*4 playing cycles (plus any paused cycles) and sounds only when
// its period is above 1.
module tb_juke_sequencer;

  localparam int TPU   = 4;
  localparam int NOTES = 3;

  logic        clock    = 1'b0;
  logic        resetn   = 1'b0;
  logic [1:0]  song_sel = 2'd0;
  logic        play_req = 1'b0;
  logic        stop_req = 1'b0;
  logic        pause    = 1'b0;
  logic [19:0] tone_period;
  logic        tone_en;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  juke_sequencer_if #(.IDX_W(10), .PER_W(20), .DUR_W(5)) rom_if ();

  juke_sequencer #(
    .TICKS_PER_UNIT (TPU),
    .SONG_LEN       (NOTES),
    .IDX_W          (10),
    .PER_W          (20),
    .DUR_W          (5)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .song_sel    (song_sel),
    .play_req    (play_req),
    .stop_req    (stop_req),
    .pause       (pause),
    .rom         (rom_if.master),
    .tone_period (tone_period),
    .tone_en     (tone_en),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Song ROM model
  logic [19:0] tbl_per [NOTES];
  logic [4:0]  tbl_dur [NOTES];
  logic        mdl_ack  = 1'b0;
  logic [19:0] mdl_per  = 20'd0;
  logic [4:0]  mdl_dur  = 5'd0;
  int          mcnt     = 0;
  logic        rom_auto = 1'b1;
  logic        inj_ack  = 1'b0;

  assign rom_if.rom_ack    = mdl_ack | inj_ack;
  assign rom_if.rom_period = mdl_per;
  assign rom_if.rom_dur    = mdl_dur;

  // ROM responder: ack during the second cycle a request is seen.
  always @(negedge clock) begin
    if (!resetn) begin
      mdl_ack <= 1'b0;
      mcnt    <= 0;
    end else if (mdl_ack) begin
      mdl_ack <= 1'b0;
      mcnt    <= 0;
    end else if (rom_if.rom_req && rom_auto) begin
      if (mcnt == 1) begin
        mdl_ack <= 1'b1;
        mcnt    <= 0;
        if (rom_if.rom_addr < 10'(NOTES)) begin
          mdl_per <= tbl_per[int'(rom_if.rom_addr)];
          mdl_dur <= tbl_dur[int'(rom_if.rom_addr)];
        end else begin
          mdl_per <= 20'd0;
          mdl_dur <= 5'd0;
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int pn);
    for (int i = 0; i < NOTES; i++) begin
      if ($urandom_range(0, 3) == 0) tbl_per[i] = 20'($urandom_range(0, 1));
      else                           tbl_per[i] = 20'($urandom_range(2, 20'hFFFFF));
      tbl_dur[i] = 5'($urandom_range(0, 3));
    end
    if (pn >= 0) begin
      if (tbl_per[pn] < 20'd2) tbl_per[pn] = 20'd1234;
      if (tbl_dur[pn] == 5'd0) tbl_dur[pn] = 5'd1;
    end
  endtask

  task automatic start_song(input logic [1:0] sel);
    song_sel = sel;
    play_req = 1'b1;
    @(negedge clock);
    play_req = 1'b0;
  endtask

  // Play one full song, pausing 3 cycles during note pn (pn < 0: no pause).
  task automatic run_song(input logic [1:0] sel, input int pn);
    int  on_cnt   [NOTES];
    int  play_cnt [NOTES];
    int  exp_len;
    int  idx;
    int  cyc      = 0;
    bit  got_done = 1'b0;
    bit  paused   = 1'b0;
    for (int i = 0; i < NOTES; i++) begin
      on_cnt[i]   = 0;
      play_cnt[i] = 0;
    end
    start_song(sel);
    chk("start_rom_song", 32'(rom_if.rom_song), 32'(sel));
    chk("start_rom_addr", 32'(rom_if.rom_addr), 32'd0);
    chk("start_rom_req",  32'(rom_if.rom_req),  32'd1);
    chk("start_busy",     32'(busy),            32'd1);
    while (!got_done && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      // A play request with a different song while busy must change nothing.
      play_req = (cyc == 5);
      song_sel = (cyc == 5) ? ~sel : sel;
      if (done) begin
        got_done = 1'b1;
      end else if (busy && !rom_if.rom_req && rom_if.rom_addr < 10'(NOTES)) begin
        idx = int'(rom_if.rom_addr);
        play_cnt[idx]++;
        if (tone_en) begin
          on_cnt[idx]++;
          chk("tone_period", 32'(tone_period), 32'(tbl_per[idx]));
        end
        if (!paused && idx == pn && tone_en && on_cnt[idx] == 2) begin
          paused = 1'b1;
          pause  = 1'b1;
          repeat (3) begin
            @(negedge clock);
            chk("pause_silent", 32'(tone_en), 32'd0);
            if (busy && !rom_if.rom_req) play_cnt[idx]++;
          end
          pause = 1'b0;
        end
      end
    end
    play_req = 1'b0;
    song_sel = sel;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("done_tone_off", 32'(tone_en), 32'd0);
`ifdef JUKE_AUTOLOOP_EN
    chk("loop_busy",     32'(busy),            32'd1);
    chk("loop_rom_addr", 32'(rom_if.rom_addr), 32'd0);
    chk("loop_rom_req",  32'(rom_if.rom_req),  32'd1);
`else
    chk("end_busy", 32'(busy), 32'd0);
`endif
    @(negedge clock);
    chk("done_one_cycle", 32'(done), 32'd0);
`ifdef JUKE_AUTOLOOP_EN
    stop_req = 1'b1;
    @(negedge clock);
    stop_req = 1'b0;
    chk("loop_stop_busy", 32'(busy), 32'd0);
`endif
    for (int i = 0; i < NOTES; i++) begin
      exp_len = ((tbl_dur[i] == 5'd0) ? 1 : int'(tbl_dur[i])) * TPU;
      chk("note_on_time", 32'(on_cnt[i]),   32'((tbl_per[i] > 20'd1) ? exp_len : 0));
      chk("note_length",  32'(play_cnt[i]), 32'(exp_len + ((i == pn) ? 3 : 0)));
    end
  endtask

  initial begin
    int wait_cyc;
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_rom_req",     32'(rom_if.rom_req),  32'd0);
    chk("rst_rom_song",    32'(rom_if.rom_song), 32'd0);
    chk("rst_rom_addr",    32'(rom_if.rom_addr), 32'd0);
    chk("rst_tone_period", 32'(tone_period),     32'd0);
    chk("rst_tone_en",     32'(tone_en),         32'd0);
    chk("rst_busy",        32'(busy),            32'd0);
    chk("rst_done",        32'(done),            32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_busy",    32'(busy),           32'd0);
    chk("idle_rom_req", 32'(rom_if.rom_req), 32'd0);

    // play_req with no song selected is ignored
    start_song(2'd0);
    chk("sel0_busy", 32'(busy), 32'd0);
    @(negedge clock);
    chk("sel0_rom_req", 32'(rom_if.rom_req), 32'd0);

    // Directed song: tone, rest, zero-duration note; pause in the first note
    tbl_per[0] = 20'd47778; tbl_dur[0] = 5'd2;
    tbl_per[1] = 20'd1;     tbl_dur[1] = 5'd2;
    tbl_per[2] = 20'd3000;  tbl_dur[2] = 5'd0;
    run_song(2'd2, 0);
    repeat (2) @(negedge clock);

    // Random songs
    for (int s = 0; s < 5; s++) begin
      int pn;
      pn = int'($urandom_range(0, 3)) - 1;
      fill_random(pn);
      run_song(2'($urandom_range(1, 3)), pn);
      repeat (2) @(negedge clock);
    end

    // stop_req during FETCH with a same-cycle play_req; a later ack is ignored
    rom_auto = 1'b0;
    start_song(2'd1);
    chk("stop_fetch_req", 32'(rom_if.rom_req), 32'd1);
    stop_req = 1'b1;
    play_req = 1'b1;
    song_sel = 2'd3;
    @(negedge clock);
    stop_req = 1'b0;
    play_req = 1'b0;
    chk("stop_busy",     32'(busy),            32'd0);
    chk("stop_rom_req",  32'(rom_if.rom_req),  32'd0);
    chk("stop_rom_addr", 32'(rom_if.rom_addr), 32'd0);
    chk("stop_tone_en",  32'(tone_en),         32'd0);
    inj_ack = 1'b1;
    @(negedge clock);
    inj_ack = 1'b0;
    @(negedge clock);
    chk("late_ack_busy",    32'(busy),    32'd0);
    chk("late_ack_tone_en", 32'(tone_en), 32'd0);
    rom_auto = 1'b1;

    // stop_req while a note is sounding
    tbl_per[0] = 20'd5000; tbl_dur[0] = 5'd3;
    start_song(2'd3);
    wait_cyc = 0;
    while (!tone_en && wait_cyc < 50) begin
      @(negedge clock);
      wait_cyc++;
    end
    chk("play_tone_on", 32'(tone_en), 32'd1);
    stop_req = 1'b1;
    @(negedge clock);
    stop_req = 1'b0;
    chk("stop_play_tone_en",  32'(tone_en),         32'd0);
    chk("stop_play_busy",     32'(busy),            32'd0);
    chk("stop_play_rom_addr", 32'(rom_if.rom_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
